// File: rtl/csr_file_if.sv
// Bus between the pipeline and the machine-mode CSR file: read port, commit port,
// retire/IRQ levels, and the trap entry/return handshake.
interface csr_file_if;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        retire;
   logic        ext_irq;
   logic        timer_irq;
   logic        int_req;
   logic        int_take;
   logic [31:0] int_pc;
   logic        mret;
   logic [31:0] trap_vector;
   logic [31:0] epc;

   // Pipeline side: drives requests, consumes read data and trap state
   modport master (
      output csr_raddr, csr_we, csr_waddr, csr_wdata, retire, ext_irq, timer_irq,
             int_take, int_pc, mret,
      input  csr_rdata, csr_illegal, int_req, trap_vector, epc
   );

   // CSR file side
   modport slave (
      input  csr_raddr, csr_we, csr_waddr, csr_wdata, retire, ext_irq, timer_irq,
             int_take, int_pc, mret,
      output csr_rdata, csr_illegal, int_req, trap_vector, epc
   );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read, next-edge commit, 64-bit cycle and
// instret counters, and the mstatus/mepc side effects of interrupt entry and mret.
module csr_file (
   input logic        clk,
   input logic        rst,
   csr_file_if.slave  bus
);
   localparam int RegBus = 32;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

   // Writable field masks; bits outside them are stored as zero so reads need no masking
   localparam logic [RegBus-1:0] MIE_MASK  = 32'h0000_0880;
   localparam logic [RegBus-1:0] ADDR_MASK = 32'hFFFF_FFFC;

   logic              mst_mie_q, mst_mie_d;
   logic              mst_mpie_q, mst_mpie_d;
   logic [RegBus-1:0] mie_q, mie_d;
   logic [RegBus-1:0] mtvec_q, mtvec_d;
   logic [RegBus-1:0] mepc_q, mepc_d;
   logic [63:0]       mcycle_q, mcycle_d;
   logic [63:0]       minstret_q, minstret_d;

   logic [RegBus-1:0] mip;
   logic [RegBus-1:0] mstatus;

   assign mip     = {20'b0, bus.ext_irq, 3'b0, bus.timer_irq, 7'b0};
   assign mstatus = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};

   assign bus.int_req     = mst_mie_q & (|(mie_q & mip));
   assign bus.trap_vector = mtvec_q;
   assign bus.epc         = mepc_q;

   // Read mux: zero-latency decode of csr_raddr, flagging unimplemented addresses
   always_comb begin
      bus.csr_rdata   = '0;
      bus.csr_illegal = 1'b0;
      case (bus.csr_raddr)
         ADDR_MSTATUS:                 bus.csr_rdata = mstatus;
         ADDR_MIE:                     bus.csr_rdata = mie_q;
         ADDR_MTVEC:                   bus.csr_rdata = mtvec_q;
         ADDR_MEPC:                    bus.csr_rdata = mepc_q;
         ADDR_MIP:                     bus.csr_rdata = mip;
         ADDR_MCYCLE,   ADDR_CYCLE:    bus.csr_rdata = mcycle_q[31:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:   bus.csr_rdata = mcycle_q[63:32];
         ADDR_MINSTRET, ADDR_INSTRET:  bus.csr_rdata = minstret_q[31:0];
         ADDR_MINSTRETH,ADDR_INSTRETH: bus.csr_rdata = minstret_q[63:32];
         default:                      bus.csr_illegal = 1'b1;
      endcase
   end

   // Next state: trap entry beats mret beats software write on mstatus/mepc;
   // a counter write replaces one half and suppresses that cycle's increment
   always_comb begin
      mst_mie_d  = mst_mie_q;
      mst_mpie_d = mst_mpie_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = bus.retire ? minstret_q + 64'd1 : minstret_q;

      if (bus.int_take) begin
         mst_mpie_d = mst_mie_q;
         mst_mie_d  = 1'b0;
         mepc_d     = bus.int_pc & ADDR_MASK;
      end else if (bus.mret) begin
         mst_mie_d  = mst_mpie_q;
         mst_mpie_d = 1'b1;
      end

      if (bus.csr_we) begin
         case (bus.csr_waddr)
            ADDR_MSTATUS: begin
               if (!bus.int_take && !bus.mret) begin
                  mst_mie_d  = bus.csr_wdata[3];
                  mst_mpie_d = bus.csr_wdata[7];
               end
            end
            ADDR_MEPC: begin
               if (!bus.int_take) mepc_d = bus.csr_wdata & ADDR_MASK;
            end
            ADDR_MIE:       mie_d      = bus.csr_wdata & MIE_MASK;
            ADDR_MTVEC:     mtvec_d    = bus.csr_wdata & ADDR_MASK;
            ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], bus.csr_wdata};
            ADDR_MCYCLEH:   mcycle_d   = {bus.csr_wdata, mcycle_q[31:0]};
            ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], bus.csr_wdata};
            ADDR_MINSTRETH: minstret_d = {bus.csr_wdata, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   // State registers; reset overrides every concurrent event
   always_ff @(posedge clk) begin
      if (rst) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mepc_q     <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mst_mie_q  <= mst_mie_d;
         mst_mpie_q <= mst_mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
endmodule
